inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 154 +++++++++++++++
 tb/tb_inst_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I instruction encoder with one-word output register and address counter
module inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [12:0] req_imm,
  input  logic        pc_load,
  input  logic [31:0] pc_load_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_BEQ = 3'd6;

  localparam logic [6:0] OPC_R    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STOR = 7'b0100011;
  localparam logic [6:0] OPC_BRAN = 7'b1100011;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_base;
  logic [31:0] enc_word;
  logic        enc_legal;
  logic        imm_fits12;
  logic        req_fire;
  logic        load_word;
  logic        reject;

  // A 13-bit immediate fits the 12-bit I/S field when its top two bits agree
  assign imm_fits12 = (req_imm[12] == req_imm[11]);

  // Build the instruction word and legality for the presented request
  always_comb begin
    enc_word  = 32'd0;
    enc_legal = 1'b0;
    case (req_op)
      OP_ADD: begin
        enc_word  = {7'b0000000, req_rs2, req_rs1, 3'b000, req_rd, OPC_R};
        enc_legal = 1'b1;
      end
      OP_SUB: begin
        enc_word  = {7'b0100000, req_rs2, req_rs1, 3'b000, req_rd, OPC_R};
        enc_legal = 1'b1;
      end
      OP_OR: begin
        enc_word  = {7'b0000000, req_rs2, req_rs1, 3'b110, req_rd, OPC_R};
        enc_legal = 1'b1;
      end
      OP_AND: begin
        enc_word  = {7'b0000000, req_rs2, req_rs1, 3'b111, req_rd, OPC_R};
        enc_legal = 1'b1;
      end
      OP_LW: begin
        enc_word  = {req_imm[11:0], req_rs1, 3'b010, req_rd, OPC_LOAD};
        enc_legal = imm_fits12;
      end
      OP_SW: begin
        enc_word  = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], OPC_STOR};
        enc_legal = imm_fits12;
      end
      OP_BEQ: begin
        enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, 3'b000,
                     req_imm[4:1], req_imm[11], OPC_BRAN};
        enc_legal = ~req_imm[0];
      end
      default: begin
        enc_word  = 32'd0;
        enc_legal = 1'b0;
      end
    endcase
  end

  // Handshake and next-state: a legal accept always lands in FULL, otherwise a drain empties
  always_comb begin
    state_d   = state_q;
    req_ready = ~rst & ((state_q == EMPTY) | out_ready);
    req_fire  = req_valid & req_ready;
    load_word = req_fire & enc_legal;
    reject    = req_fire & ~enc_legal;
    case (state_q)
      EMPTY: begin
        if (load_word) state_d = FULL;
      end
      FULL: begin
        if (load_word)      state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // State register; reset drops any held word
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  assign out_valid = (state_q == FULL);

  // A same-cycle reload takes effect before the accepting word claims its address
  assign pc_base = pc_load ? pc_load_val : pc_q;

  // Output word register: captured only on a legal accept, held stable otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      out_inst <= 32'd0;
      out_addr <= 32'd0;
    end else if (load_word) begin
      out_inst <= enc_word;
      out_addr <= pc_base;
    end
  end

  // Address counter: advances by one word per legal accept, wraps naturally
  always_ff @(posedge clk) begin
    if (rst)            pc_q <= 32'd0;
    else if (load_word) pc_q <= pc_base + 32'd4;
    else                pc_q <= pc_base;
  end

  // Rejected-request pulse and saturating count
  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= reject;
      if (reject && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - self-checking bench for inst_encoder
module tb_inst_encoder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [12:0] req_imm;
  logic        pc_load;
  logic [31:0] pc_load_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int failures = 0;

  inst_encoder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .pc_load(pc_load), .pc_load_val(pc_load_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          started = 0;
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  bit          m_err;
  int          m_cnt;

  function automatic bit m_legal(input int op, input int imm);
    if (op == 7) return 0;
    if (op == 4 || op == 5) return (imm >= -2048 && imm <= 2047);
    if (op == 6) return (imm % 2) == 0;
    return 1;
  endfunction

  function automatic logic [31:0] m_enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    int f3[4] = '{0, 0, 6, 7};
    logic [31:0] w;
    case (op)
      0, 1, 2, 3: w = ((op == 1 ? 32 : 0) << 25) | (rs2 << 20) | (rs1 << 15) | (f3[op] << 12) | (rd << 7) | 'h33;
      4: w = ((imm & 'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
      5: w = (((imm >>> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) | ((imm & 31) << 7) | 'h23;
      default: w = (((imm >>> 12) & 1) << 31) | (((imm >>> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
                   | (((imm >>> 1) & 15) << 8) | (((imm >>> 11) & 1) << 7) | 'h63;
    endcase
    return w;
  endfunction

  // Model advances on each rising edge from the inputs the bench is presenting
  always @(posedge clk) begin
    int imm_s;
    bit take;
    logic [31:0] base;
    if (rst) begin
      started = 1;
      m_valid = 0; m_inst = 0; m_addr = 0; m_pc = 0; m_err = 0; m_cnt = 0;
    end else begin
      take  = req_valid && (!m_valid || out_ready);
      base  = pc_load ? pc_load_val : m_pc;
      imm_s = int'($signed(req_imm));
      m_err = 0;
      if (m_valid && out_ready) m_valid = 0;
      if (take) begin
        if (m_legal(int'(req_op), imm_s)) begin
          m_valid = 1;
          m_inst  = m_enc(int'(req_op), int'(req_rd), int'(req_rs1), int'(req_rs2), imm_s);
          m_addr  = base;
          base    = base + 32'd4;
        end else begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
        end
      end
      m_pc = base;
    end
  end

  // Every cycle: compare DUT against the model once inputs for the cycle are settled
  always @(negedge clk) begin
    #2;
    if (started) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, (!rst && (!m_valid || out_ready))});
      check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      check("err", {31'd0, err}, {31'd0, m_err});
      check("err_cnt", {24'd0, err_cnt}, 32'(m_cnt));
      if (m_valid) begin
        check("out_inst", out_inst, m_inst);
        check("out_addr", out_addr, m_addr);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic req(input logic v, input logic [2:0] op, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    req_valid = v; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
  endtask

  task automatic idle();
    req(1'b0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; idle(); pc_load = 0; out_ready = 1;
    @(negedge clk); #3;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_cnt", {24'd0, err_cnt}, 32'd0);
    @(negedge clk); rst = 0; out_ready = 0;
  endtask

  int imm_tab[8] = '{-2048, 2047, 100, -6, -2049, 2048, 4094, 7};

  initial begin
    rst = 1; idle(); pc_load = 0; pc_load_val = 0; out_ready = 0;
    do_reset();

    // ADD rd=1 rs1=2 rs2=3, latency 1, address 0
    req(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 13'd0);
    @(negedge clk); idle(); out_ready = 1; #3;
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_inst", out_inst, 32'h003100B3);
    check("add_addr", out_addr, 32'h0);

    // SUB then LW back to back from a fresh reset
    do_reset();
    out_ready = 1;
    req(1'b1, 3'd1, 5'd5, 5'd6, 5'd7, 13'd0);
    @(negedge clk); req(1'b1, 3'd4, 5'd8, 5'd2, 5'd0, 13'(-4)); #3;
    check("sub_inst", out_inst, 32'h407302B3);
    check("sub_addr", out_addr, 32'h0);
    @(negedge clk); idle(); #3;
    check("lw_valid", {31'd0, out_valid}, 32'd1);
    check("lw_inst", out_inst, 32'hFFC12403);
    check("lw_addr", out_addr, 32'h4);

    // BEQ held under back-pressure; a pending ADD waits for out_ready
    @(negedge clk); out_ready = 0; req(1'b1, 3'd6, 5'd0, 5'd1, 5'd2, 13'd8);
    @(negedge clk); req(1'b1, 3'd0, 5'd9, 5'd10, 5'd11, 13'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      check("beq_inst", out_inst, 32'h00208463);
      check("beq_ready", {31'd0, req_ready}, 32'd0);
    end
    out_ready = 1;
    @(negedge clk); idle(); #3;
    check("add2_addr", out_addr, 32'hC);

    // Three rejected requests: no word, pc held
    @(negedge clk); req(1'b1, 3'd5, 5'd0, 5'd1, 5'd2, 13'd4096);
    @(negedge clk); req(1'b1, 3'd7, 5'd1, 5'd1, 5'd1, 13'd0);
    @(negedge clk); req(1'b1, 3'd6, 5'd0, 5'd1, 5'd2, 13'd3);
    @(negedge clk); req(1'b1, 3'd2, 5'd4, 5'd5, 5'd6, 13'd0); #3;
    check("rej_err", {31'd0, err}, 32'd1);
    check("rej_cnt", {24'd0, err_cnt}, 32'd3);
    check("rej_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk); idle(); #3;
    check("after_rej_addr", out_addr, 32'h10);

    // pc reload with simultaneous accept, then wrap
    @(negedge clk); pc_load = 1; pc_load_val = 32'hFFFFFFFC; req(1'b1, 3'd3, 5'd1, 5'd1, 5'd1, 13'd0);
    @(negedge clk); pc_load = 0; req(1'b1, 3'd0, 5'd2, 5'd2, 5'd2, 13'd0); #3;
    check("load_addr", out_addr, 32'hFFFFFFFC);
    @(negedge clk); idle(); #3;
    check("wrap_addr", out_addr, 32'h0);

    // Reset while FULL discards the word and clears pc/err_cnt
    @(negedge clk); out_ready = 0; req(1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 13'd0);
    @(negedge clk); req(1'b1, 3'd0, 5'd3, 5'd3, 5'd3, 13'd0);
    @(negedge clk); idle(); rst = 1;
    @(negedge clk); rst = 0; #3;
    check("rstfull_valid", {31'd0, out_valid}, 32'd0);
    check("rstfull_cnt", {24'd0, err_cnt}, 32'd0);
    req(1'b1, 3'd0, 5'd1, 5'd2, 5'd3, 13'd0);
    @(negedge clk); idle(); out_ready = 1; #3;
    check("rstfull_addr", out_addr, 32'h0);

    // Mixed ops and immediate boundaries with alternating back-pressure
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      out_ready = (i % 3) != 1;
      req(1'b1, 3'(i % 8), 5'(i + 3), 5'(i * 7), 5'(31 - i), 13'(imm_tab[i % 8]));
    end
    @(negedge clk); idle(); out_ready = 1;

    // Illegal accept with a simultaneous drain leaves EMPTY; then saturate the counter
    for (int i = 0; i < 260; i++) begin
      @(negedge clk); req(1'b1, 3'd7, 5'd0, 5'd0, 5'd0, 13'd0);
    end
    @(negedge clk); idle(); #3;
    check("sat_cnt", {24'd0, err_cnt}, 32'd255);
    check("sat_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
